// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types, constants and helpers for the packetising UART TX scheduler.
package uart_tx_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2,
    CSUM    = 2'd3
  } state_e;

  localparam logic [7:0] HDR_MARK = 8'hA0;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } req_beat_t;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [7:0] hdr_byte(input logic [2:0] id);
    return HDR_MARK | {5'b0, id};
  endfunction

  function automatic logic [7:0] csum_next(input logic [7:0] csum, input logic [7:0] b);
    return csum ^ b;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester and serialiser signals of the UART TX scheduler.
interface uart_tx_scheduler_if
  import uart_tx_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
);
  localparam int unsigned ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           uart_byte;
  logic                 uart_valid;
  logic                 uart_ready;
  logic                 uart_done;
  logic [ID_W-1:0]      grant_id;
  logic                 busy;

  // Scheduler side
  modport master (
    input  req_valid, req_data, req_last, uart_ready, uart_done,
    output req_ready, uart_byte, uart_valid, grant_id, busy
  );

  // Requesters and serialiser side
  modport slave (
    output req_valid, req_data, req_last, uart_ready, uart_done,
    input  req_ready, uart_byte, uart_valid, grant_id, busy
  );

endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module uart_tx_scheduler_rr_arbiter
  import uart_tx_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt_c,
  output logic [ID_W-1:0]    idx_c,
  output logic               any_c
);

  // Pass one covers ptr..NUM_REQ-1, pass two wraps to the lowest index.
  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    any_c = 1'b0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (!any_c && req[k] && (k >= int'(ptr))) begin
        any_c    = 1'b1;
        gnt_c[k] = 1'b1;
        idx_c    = ID_W'(k);
      end
    end
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (!any_c && req[k]) begin
        any_c    = 1'b1;
        gnt_c[k] = 1'b1;
        idx_c    = ID_W'(k);
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART serialiser between NUM_REQ requesters, one framed packet
// (header, payload, XOR checksum) at a time with round-robin grant.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned MAX_LEN = 16
) (
  input logic              clk,
  input logic              rst_n,
  uart_tx_scheduler_if.master bus
);

  localparam int unsigned ID_W  = id_width(NUM_REQ);
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

  state_e               state_q, state_d;
  logic                 in_flight_q;
  logic [LEN_W-1:0]     len_q;
  logic                 last_q;
  logic [7:0]           csum_q;
  logic [ID_W-1:0]      ptr_q;
  logic [ID_W-1:0]      grant_q;
  logic [NUM_REQ-1:0]   grant_oh_q;
  logic [7:0]           uart_byte_q;
  logic                 uart_valid_q;
  logic [NUM_REQ-1:0]   req_ready_q;
  logic                 busy_q;

  logic [NUM_REQ-1:0]   arb_gnt_c;
  logic [ID_W-1:0]      arb_idx_c;
  logic                 arb_any_c;
  logic                 sel_valid_c;
  req_beat_t            sel_beat_c;
  logic                 can_issue_c;
  logic                 done_c;
  logic                 grab_c;
  logic                 issue_c;
  logic                 take_c;
  logic [7:0]           issue_byte_c;

  uart_tx_scheduler_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req   (bus.req_valid),
    .ptr   (ptr_q),
    .gnt_c (arb_gnt_c),
    .idx_c (arb_idx_c),
    .any_c (arb_any_c)
  );

  // Granted requester's beat.
  always_comb begin
    sel_valid_c = 1'b0;
    sel_beat_c  = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (grant_oh_q[k]) begin
        sel_valid_c     = bus.req_valid[k];
        sel_beat_c.data = bus.req_data[8*k +: 8];
        sel_beat_c.last = bus.req_last[k];
      end
    end
  end

  // No issue in the uart_done cycle, so one byte per done even if ready drops late.
  assign can_issue_c = bus.uart_ready && !in_flight_q && !bus.uart_done;
  assign done_c      = bus.uart_done && in_flight_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_any_c) state_d = HDR;
      HDR:     if (done_c) state_d = PAYLOAD;
      PAYLOAD: if (done_c && (last_q || (len_q == LEN_W'(MAX_LEN)))) state_d = CSUM;
      CSUM:    if (done_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grab_c       = 1'b0;
    issue_c      = 1'b0;
    take_c       = 1'b0;
    issue_byte_c = '0;
    case (state_q)
      IDLE: grab_c = arb_any_c;
      HDR: begin
        if (can_issue_c) begin
          issue_c      = 1'b1;
          issue_byte_c = hdr_byte(3'(grant_q));
        end
      end
      PAYLOAD: begin
        if (can_issue_c && sel_valid_c) begin
          issue_c      = 1'b1;
          take_c       = 1'b1;
          issue_byte_c = sel_beat_c.data;
        end
      end
      CSUM: begin
        if (can_issue_c) begin
          issue_c      = 1'b1;
          issue_byte_c = csum_q;
        end
      end
      default: ;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_flight_q  <= 1'b0;
      len_q        <= '0;
      last_q       <= 1'b0;
      csum_q       <= '0;
      ptr_q        <= '0;
      grant_q      <= '0;
      grant_oh_q   <= '0;
      uart_byte_q  <= '0;
      uart_valid_q <= 1'b0;
      req_ready_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      uart_valid_q <= issue_c;
      req_ready_q  <= take_c ? grant_oh_q : '0;
      busy_q       <= (state_d != IDLE);

      if (issue_c)            in_flight_q <= 1'b1;
      else if (bus.uart_done) in_flight_q <= 1'b0;

      if (issue_c) uart_byte_q <= issue_byte_c;

      if (grab_c) begin
        grant_q    <= arb_idx_c;
        grant_oh_q <= arb_gnt_c;
        ptr_q      <= (arb_idx_c == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx_c + ID_W'(1);
      end

      if (issue_c && (state_q == HDR)) csum_q <= issue_byte_c;
      else if (take_c)                 csum_q <= csum_next(csum_q, sel_beat_c.data);
      else if (done_c && (state_q == CSUM)) csum_q <= '0;

      if (take_c) begin
        len_q  <= len_q + LEN_W'(1);
        last_q <= sel_beat_c.last;
      end else if (done_c && (state_q == CSUM)) begin
        len_q  <= '0;
        last_q <= 1'b0;
      end
    end
  end

  assign bus.uart_byte  = uart_byte_q;
  assign bus.uart_valid = uart_valid_q;
  assign bus.req_ready  = req_ready_q;
  assign bus.grant_id   = grant_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench: directed packets, serialiser/requester models, wire bytes checked in order.
module tb_uart_tx_scheduler;
  import uart_tx_scheduler_pkg::*;

  localparam int unsigned NREQ  = 2;
  localparam int unsigned MLEN  = 16;
  localparam int          FRAME = 10;

  logic clk;
  logic rst_n;

  uart_tx_scheduler_if #(.NUM_REQ(NREQ)) bus_if ();

  uart_tx_scheduler #(.NUM_REQ(NREQ), .MAX_LEN(MLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  req_beat_t  rq0[$];
  req_beat_t  rq1[$];
  logic [7:0] exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         rr_cnt0  = 0;
  int         rr_cnt1  = 0;
  bit         ser_busy = 1'b0;
  int         ser_cnt  = 0;
  bit         late_drop = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h", name, act, want);
    end
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    req_beat_t b;
    b.data = d;
    b.last = l;
    if (r == 0) rq0.push_back(b);
    else        rq1.push_back(b);
  endtask

  task automatic expect_bytes(input logic [7:0] b);
    exp_q.push_back(b);
  endtask

  // Requesters and serialiser model plus scoreboard monitor, all on the falling edge.
  initial begin
    bus_if.req_valid  = '0;
    bus_if.req_data   = '0;
    bus_if.req_last   = '0;
    bus_if.uart_ready = 1'b1;
    bus_if.uart_done  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ser_busy          = 1'b0;
        ser_cnt           = 0;
        bus_if.uart_done  = 1'b0;
        bus_if.uart_ready = 1'b1;
      end else begin
        bus_if.uart_done = 1'b0;
        if (bus_if.req_ready != '0) begin
          chk("req_ready_onehot", 32'($onehot(bus_if.req_ready)), 32'd1);
          if (bus_if.req_ready[0]) begin
            chk("req0_pop_nonempty", 32'(rq0.size() != 0), 32'd1);
            if (rq0.size() != 0) void'(rq0.pop_front());
            rr_cnt0++;
          end
          if (bus_if.req_ready[1]) begin
            chk("req1_pop_nonempty", 32'(rq1.size() != 0), 32'd1);
            if (rq1.size() != 0) void'(rq1.pop_front());
            rr_cnt1++;
          end
        end
        if (bus_if.uart_valid) begin
          chk("issue_while_serialiser_busy", 32'(ser_busy), 32'd0);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_byte got %0h want none", bus_if.uart_byte);
          end else begin
            chk("uart_byte", 32'(bus_if.uart_byte), 32'(exp_q.pop_front()));
          end
          ser_busy          = 1'b1;
          ser_cnt           = FRAME;
          bus_if.uart_ready = late_drop;
        end else if (ser_busy) begin
          bus_if.uart_ready = 1'b0;
          ser_cnt--;
          if (ser_cnt == 0) begin
            ser_busy          = 1'b0;
            bus_if.uart_done  = 1'b1;
            bus_if.uart_ready = 1'b1;
          end
        end
      end
      bus_if.req_valid[0] = (rq0.size() != 0);
      bus_if.req_data[7:0] = (rq0.size() != 0) ? rq0[0].data : 8'h00;
      bus_if.req_last[0]  = (rq0.size() != 0) ? rq0[0].last : 1'b0;
      bus_if.req_valid[1] = (rq1.size() != 0);
      bus_if.req_data[15:8] = (rq1.size() != 0) ? rq1[0].data : 8'h00;
      bus_if.req_last[1]  = (rq1.size() != 0) ? rq1[0].last : 1'b0;
    end
  end

  task automatic wait_done(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || bus_if.busy || ser_busy) && t < 3000) begin
      @(posedge clk); #2;
      t++;
    end
    chk({name, "_timeout"}, 32'(t >= 3000), 32'd0);
    chk({name, "_busy_low"}, 32'(bus_if.busy), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rq0.delete();
    rq1.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int base;
    int t;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_uart_valid", 32'(bus_if.uart_valid), 32'd0);
    chk("rst_uart_byte",  32'(bus_if.uart_byte),  32'd0);
    chk("rst_req_ready",  32'(bus_if.req_ready),  32'd0);
    chk("rst_grant_id",   32'(bus_if.grant_id),   32'd0);
    chk("rst_busy",       32'(bus_if.busy),       32'd0);
    rst_n = 1'b1;

    // Basic two-byte packet from req0
    expect_bytes(8'hA0); expect_bytes(8'h11); expect_bytes(8'h22); expect_bytes(8'h93);
    push(0, 8'h11, 1'b0);
    push(0, 8'h22, 1'b1);
    wait_done("t1");
    chk("t1_req0_pulses", 32'(rr_cnt0), 32'd2);
    chk("t1_req1_pulses", 32'(rr_cnt1), 32'd0);

    // Round robin from pointer 0
    do_reset();
    expect_bytes(8'hA0); expect_bytes(8'h33); expect_bytes(8'h93);
    expect_bytes(8'hA1); expect_bytes(8'h44); expect_bytes(8'hE5);
    expect_bytes(8'hA0); expect_bytes(8'h55); expect_bytes(8'hF5);
    push(0, 8'h33, 1'b1);
    push(0, 8'h55, 1'b1);
    push(1, 8'h44, 1'b1);
    wait_done("t2");
    chk("t2_grant_id", 32'(bus_if.grant_id), 32'd0);

    // Forced end at MAX_LEN, remainder forms the next packet
    base = rr_cnt1;
    expect_bytes(8'hA1);
    for (int i = 1; i <= 16; i++) expect_bytes(8'(i));
    expect_bytes(8'hB1);
    expect_bytes(8'hA1);
    for (int i = 17; i <= 20; i++) expect_bytes(8'(i));
    expect_bytes(8'hA5);
    for (int i = 1; i <= 20; i++) push(1, 8'(i), 1'(i == 20));
    wait_done("t3");
    chk("t3_req1_pulses", 32'(rr_cnt1 - base), 32'd20);
    chk("t3_grant_id", 32'(bus_if.grant_id), 32'd1);

    // Serialiser keeps ready high one cycle after accepting
    late_drop = 1'b1;
    expect_bytes(8'hA0); expect_bytes(8'h5A); expect_bytes(8'hC3); expect_bytes(8'h39);
    push(0, 8'h5A, 1'b0);
    push(0, 8'hC3, 1'b1);
    wait_done("t4");
    late_drop = 1'b0;

    // Granted requester stalls mid-packet; other requester waits
    base = rr_cnt1;
    expect_bytes(8'hA1); expect_bytes(8'h10); expect_bytes(8'h20);
    push(1, 8'h10, 1'b0);
    push(1, 8'h20, 1'b0);
    t = 0;
    while ((exp_q.size() != 0 || ser_busy) && t < 1000) begin
      @(posedge clk); #2;
      t++;
    end
    chk("t5_first_bytes_timeout", 32'(t >= 1000), 32'd0);
    push(0, 8'h66, 1'b1);
    repeat (50) @(posedge clk);
    #2;
    chk("t5_stall_grant_id", 32'(bus_if.grant_id), 32'd1);
    chk("t5_stall_busy", 32'(bus_if.busy), 32'd1);
    chk("t5_stall_req1_pulses", 32'(rr_cnt1 - base), 32'd2);
    chk("t5_stall_req0_waiting", 32'(rq0.size()), 32'd1);
    expect_bytes(8'h30); expect_bytes(8'hA1);
    expect_bytes(8'hA0); expect_bytes(8'h66); expect_bytes(8'hC6);
    push(1, 8'h30, 1'b1);
    wait_done("t5");

    // Reset during PAYLOAD
    base = rr_cnt0;
    expect_bytes(8'hA0); expect_bytes(8'h77);
    push(0, 8'h77, 1'b0);
    push(0, 8'h88, 1'b1);
    t = 0;
    while (rr_cnt0 == base && t < 500) begin
      @(posedge clk); #2;
      t++;
    end
    chk("t6_payload_timeout", 32'(t >= 500), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_uart_valid", 32'(bus_if.uart_valid), 32'd0);
    chk("t6_rst_uart_byte",  32'(bus_if.uart_byte),  32'd0);
    chk("t6_rst_req_ready",  32'(bus_if.req_ready),  32'd0);
    chk("t6_rst_grant_id",   32'(bus_if.grant_id),   32'd0);
    chk("t6_rst_busy",       32'(bus_if.busy),       32'd0);
    rq0.delete();
    rq1.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    expect_bytes(8'hA0); expect_bytes(8'h99); expect_bytes(8'h39);
    push(0, 8'h99, 1'b1);
    wait_done("t6");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
